// File: rtl/prover_v_round_ctrl_if.sv
// Handshake and bank-facing signal bundle for prover_v_round_ctrl.
// The slave modport is the controller's view; master is the host/bank side.
`ifndef F_NBITS
`define F_NBITS 16
`endif
`ifndef F_Q
`define F_Q 65521
`endif

interface prover_v_round_ctrl_if #(
  parameter int unsigned nRndBits = 4
);
  logic                    start;
  logic                    start_ready;
  logic                    abort;
  logic [`F_NBITS-1:0]     tau_in;
  logic                    tau_valid;
  logic                    tau_ready;
  logic                    bank_en;
  logic                    bank_restart;
  logic [`F_NBITS-1:0]     bank_tau;
  logic [`F_NBITS-1:0]     bank_m_tau_p1;
  logic                    bank_ready_pulse;
  logic                    bank_final_ready;
  logic [`F_NBITS-1:0]     bank_final_out;
  logic [`F_NBITS-1:0]     result;
  logic                    result_valid;
  logic                    result_ready;
  logic                    result_err;
  logic [nRndBits-1:0]     round;
  logic                    busy;

  modport slave (
    input  start, abort, tau_in, tau_valid, bank_ready_pulse, bank_final_ready,
           bank_final_out, result_ready,
    output start_ready, tau_ready, bank_en, bank_restart, bank_tau, bank_m_tau_p1,
           result, result_valid, result_err, round, busy
  );

  modport master (
    output start, abort, tau_in, tau_valid, bank_ready_pulse, bank_final_ready,
           bank_final_out, result_ready,
    input  start_ready, tau_ready, bank_en, bank_restart, bank_tau, bank_m_tau_p1,
           result, result_valid, result_err, round, busy
  );
endinterface

// File: rtl/prover_v_round_ctrl.sv
// Sum-check round sequencer: collects one challenge per round, fires the fold bank,
// and captures the bank's final value after nCopyBits rounds.
`ifndef F_NBITS
`define F_NBITS 16
`endif
`ifndef F_Q
`define F_Q 65521
`endif

module prover_v_round_ctrl #(
  parameter int unsigned nCopyBits = 8,
  parameter int unsigned nRndBits  = $clog2(nCopyBits + 1)
) (
  input logic                  clk,
  input logic                  rst,
  prover_v_round_ctrl_if.slave bus
);

  localparam int unsigned          FW       = `F_NBITS;
  localparam logic [FW:0]          QExt     = (FW + 1)'(`F_Q);
  localparam logic [FW-1:0]        QVal     = FW'(`F_Q);
  localparam logic [nRndBits-1:0]  RoundMax = nRndBits'(nCopyBits);

  typedef enum logic [2:0] {
    StIdle,
    StWaitTau,
    StFire,
    StWaitBank,
    StDone,
    StDrain
  } state_e;

  state_e              state_q, state_d;
  logic [nRndBits-1:0] round_q, round_d, round_inc;
  logic                restart_pending_q, restart_pending_d;
  logic [FW-1:0]       bank_tau_q, bank_tau_d;
  logic [FW-1:0]       m_tau_q, m_tau_d;
  logic [FW:0]         m_tau_ext;
  logic [FW-1:0]       result_q, result_d;
  logic                result_err_q, result_err_d;

  // (1 - tau) mod q lifted into [1, q]; the extra bit keeps q + 1 - tau from wrapping.
  always_comb begin
    m_tau_ext = QExt + (FW + 1)'(1) - {1'b0, bus.tau_in};
    if (bus.tau_in == '0) begin
      m_tau_ext = (FW + 1)'(1);
    end
  end

  assign round_inc = (round_q == RoundMax) ? round_q : round_q + 1'b1;

  always_comb begin
    state_d           = state_q;
    round_d           = round_q;
    restart_pending_d = restart_pending_q;
    bank_tau_d        = bank_tau_q;
    m_tau_d           = m_tau_q;
    result_d          = result_q;
    result_err_d      = result_err_q;

    unique case (state_q)
      StIdle: begin
        if (bus.start && !bus.abort) begin
          state_d           = StWaitTau;
          round_d           = '0;
          restart_pending_d = 1'b1;
        end
      end
      StWaitTau: begin
        if (bus.abort) begin
          state_d = StIdle;
        end else if (bus.tau_valid) begin
          bank_tau_d = bus.tau_in;
          m_tau_d    = m_tau_ext[FW-1:0];
          state_d    = StFire;
        end
      end
      StFire: begin
        if (bus.abort) begin
          state_d = StIdle;
        end else begin
          restart_pending_d = 1'b0;
          state_d           = StWaitBank;
        end
      end
      StWaitBank: begin
        if (bus.abort) begin
          state_d = StDrain;
        end else if (bus.bank_ready_pulse) begin
          round_d = round_inc;
          if (round_inc == RoundMax) begin
            // Capture on the final pulse so result_valid rises the very next cycle.
            state_d      = StDone;
            result_d     = bus.bank_final_out;
            result_err_d = ~bus.bank_final_ready;
          end else begin
            state_d = StWaitTau;
          end
        end
      end
      StDone: begin
        if (bus.abort || bus.result_ready) begin
          state_d = StIdle;
        end
      end
      StDrain: begin
        // The bank is mid-round; wait it out so the next restart is clean.
        if (bus.bank_ready_pulse) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q           <= StIdle;
      round_q           <= '0;
      restart_pending_q <= 1'b0;
      bank_tau_q        <= '0;
      m_tau_q           <= '0;
      result_q          <= '0;
      result_err_q      <= 1'b0;
    end else begin
      state_q           <= state_d;
      round_q           <= round_d;
      restart_pending_q <= restart_pending_d;
      bank_tau_q        <= bank_tau_d;
      m_tau_q           <= m_tau_d;
      result_q          <= result_d;
      result_err_q      <= result_err_d;
    end
  end

  // Abort during FIRE must cancel the trigger in the same cycle.
  assign bus.bank_en       = (state_q == StFire) && !bus.abort;
  assign bus.bank_restart  = bus.bank_en && restart_pending_q;
  assign bus.start_ready   = (state_q == StIdle);
  assign bus.busy          = (state_q != StIdle);
  assign bus.tau_ready     = (state_q == StWaitTau);
  assign bus.result_valid  = (state_q == StDone);
  assign bus.bank_tau      = bank_tau_q;
  assign bus.bank_m_tau_p1 = m_tau_q;
  assign bus.result        = result_q;
  assign bus.result_err    = result_err_q;
  assign bus.round         = round_q;

  a_tau_in_range: assert property (@(posedge clk) disable iff (rst)
    (bus.tau_valid && bus.tau_ready) |-> (bus.tau_in < QVal));

  a_fire_one_cycle: assert property (@(posedge clk) disable iff (rst)
    (state_q == StFire) |=> (state_q != StFire));

  a_round_saturates: assert property (@(posedge clk) disable iff (rst)
    round_q <= RoundMax);

  a_m_tau_in_field: assert property (@(posedge clk) disable iff (rst)
    (state_q == StFire) |-> (m_tau_q != '0 && m_tau_q <= QVal));

  a_bank_args_stable: assert property (@(posedge clk) disable iff (rst)
    (state_q == StWaitBank) |=> ($stable(bank_tau_q) && $stable(m_tau_q)));

endmodule

// File: tb/tb_prover_v_round_ctrl.sv
// Directed bench for prover_v_round_ctrl with nCopyBits=2: a per-cycle vector table
// plus hand sequences for result hold, long tau stalls and asynchronous reset.
`ifndef F_NBITS
`define F_NBITS 16
`endif
`ifndef F_Q
`define F_Q 65521
`endif

module tb_prover_v_round_ctrl;

  localparam int unsigned NCopy = 2;
  localparam int unsigned NRnd  = $clog2(NCopy + 1);
  localparam int unsigned FW    = `F_NBITS;
  localparam int unsigned Q     = `F_Q;

  typedef struct {
    logic          st;
    logic          ab;
    logic          tv;
    logic [FW-1:0] tau;
    logic          pl;
    logic          fr;
    logic [FW-1:0] fo;
    logic          rr;
    logic [63:0]   exp;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_errs   = 0;
  vec_t vecs[$];

  prover_v_round_ctrl_if #(.nRndBits(NRnd)) bus ();

  prover_v_round_ctrl #(
    .nCopyBits(NCopy),
    .nRndBits (NRnd)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] pack(input logic sr, tr, en, rs, rv, re, by,
                                       input logic [NRnd-1:0] rnd,
                                       input logic [FW-1:0] btau, mtau, res);
    return 64'({sr, tr, en, rs, rv, re, by, rnd, btau, mtau, res});
  endfunction

  function automatic logic [63:0] pack_dut();
    return pack(bus.start_ready, bus.tau_ready, bus.bank_en, bus.bank_restart,
                bus.result_valid, bus.result_err, bus.busy, bus.round,
                bus.bank_tau, bus.bank_m_tau_p1, bus.result);
  endfunction

  // Row: inputs st ab tv tau pl fr fo rr | outputs sr tr en rs rv re busy round btau mtau res
  function automatic void add(input int unsigned st, ab, tv, tau, pl, fr, fo, rr,
                              input int unsigned sr, tr, en, rs, rv, re, by, rnd,
                              input int unsigned btau, mtau, res);
    vec_t v;
    v.st  = st[0];
    v.ab  = ab[0];
    v.tv  = tv[0];
    v.tau = FW'(tau);
    v.pl  = pl[0];
    v.fr  = fr[0];
    v.fo  = FW'(fo);
    v.rr  = rr[0];
    v.exp = pack(sr[0], tr[0], en[0], rs[0], rv[0], re[0], by[0], NRnd'(rnd),
                 FW'(btau), FW'(mtau), FW'(res));
    vecs.push_back(v);
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step(input int unsigned st, ab, tv, tau, pl, fr, fo, rr);
    @(negedge clk);
    bus.start            = st[0];
    bus.abort            = ab[0];
    bus.tau_valid        = tv[0];
    bus.tau_in           = FW'(tau);
    bus.bank_ready_pulse = pl[0];
    bus.bank_final_ready = fr[0];
    bus.bank_final_out   = FW'(fo);
    bus.result_ready     = rr[0];
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [63:0] exp_done;
    logic [63:0] reset_pack;
    reset_pack = pack(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0, '0, '0);

    // Main flow, tau edge values, drain abort, aborts in WAIT_TAU and FIRE.
    add(0,0,0,0,0,0,0,0,        1,0,0,0,0,0,0,0, 0,0,0);
    add(1,0,0,0,0,0,0,0,        1,0,0,0,0,0,0,0, 0,0,0);
    add(0,0,1,5,0,0,0,0,        0,1,0,0,0,0,1,0, 0,0,0);
    add(0,0,0,0,0,0,0,0,        0,0,1,1,0,0,1,0, 5,Q-4,0);
    add(1,0,0,0,0,0,0,0,        0,0,0,0,0,0,1,0, 5,Q-4,0);
    add(0,0,0,0,1,0,0,0,        0,0,0,0,0,0,1,0, 5,Q-4,0);
    add(0,0,1,7,0,0,0,0,        0,1,0,0,0,0,1,1, 5,Q-4,0);
    add(0,0,0,0,0,0,0,0,        0,0,1,0,0,0,1,1, 7,Q-6,0);
    add(0,0,0,0,1,1,'h1234,0,   0,0,0,0,0,0,1,1, 7,Q-6,0);
    add(1,0,0,0,1,0,0,0,        0,0,0,0,1,0,1,2, 7,Q-6,'h1234);
    add(0,0,0,0,0,0,0,1,        0,0,0,0,1,0,1,2, 7,Q-6,'h1234);
    add(0,0,0,0,0,0,0,0,        1,0,0,0,0,0,0,2, 7,Q-6,'h1234);
    add(1,0,0,0,0,0,0,0,        1,0,0,0,0,0,0,2, 7,Q-6,'h1234);
    add(0,0,1,0,0,0,0,0,        0,1,0,0,0,0,1,0, 7,Q-6,'h1234);
    add(0,0,0,0,0,0,0,0,        0,0,1,1,0,0,1,0, 0,1,'h1234);
    add(0,0,0,0,1,0,0,0,        0,0,0,0,0,0,1,0, 0,1,'h1234);
    add(0,0,0,0,1,0,0,0,        0,1,0,0,0,0,1,1, 0,1,'h1234);
    add(0,0,1,Q-1,0,0,0,0,      0,1,0,0,0,0,1,1, 0,1,'h1234);
    add(0,0,0,0,0,0,0,0,        0,0,1,0,0,0,1,1, Q-1,2,'h1234);
    add(0,1,0,0,0,0,0,0,        0,0,0,0,0,0,1,1, Q-1,2,'h1234);
    add(1,0,0,0,0,0,0,0,        0,0,0,0,0,0,1,1, Q-1,2,'h1234);
    add(0,0,0,0,1,1,'h5555,0,   0,0,0,0,0,0,1,1, Q-1,2,'h1234);
    add(0,0,0,0,0,0,0,0,        1,0,0,0,0,0,0,1, Q-1,2,'h1234);
    add(1,0,0,0,0,0,0,0,        1,0,0,0,0,0,0,1, Q-1,2,'h1234);
    add(0,0,1,9,0,0,0,0,        0,1,0,0,0,0,1,0, Q-1,2,'h1234);
    add(0,0,0,0,0,0,0,0,        0,0,1,1,0,0,1,0, 9,Q-8,'h1234);
    add(0,0,0,0,1,0,0,0,        0,0,0,0,0,0,1,0, 9,Q-8,'h1234);
    add(0,1,1,3,0,0,0,0,        0,1,0,0,0,0,1,1, 9,Q-8,'h1234);
    add(0,0,0,0,0,0,0,0,        1,0,0,0,0,0,0,1, 9,Q-8,'h1234);
    add(1,0,0,0,0,0,0,0,        1,0,0,0,0,0,0,1, 9,Q-8,'h1234);
    add(0,0,1,4,0,0,0,0,        0,1,0,0,0,0,1,0, 9,Q-8,'h1234);
    add(0,1,0,0,0,0,0,0,        0,0,0,0,0,0,1,0, 4,Q-3,'h1234);
    add(0,0,0,0,0,0,0,0,        1,0,0,0,0,0,0,0, 4,Q-3,'h1234);

    rst                  = 1'b1;
    bus.start            = 1'b0;
    bus.abort            = 1'b0;
    bus.tau_valid        = 1'b0;
    bus.tau_in           = '0;
    bus.bank_ready_pulse = 1'b0;
    bus.bank_final_ready = 1'b0;
    bus.bank_final_out   = '0;
    bus.result_ready     = 1'b0;
    #2;
    check("reset_state", pack_dut(), reset_pack);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].st, vecs[i].ab, vecs[i].tv, vecs[i].tau, vecs[i].pl, vecs[i].fr,
           vecs[i].fo, vecs[i].rr);
      #1;
      check($sformatf("vec%0d", i), pack_dut(), vecs[i].exp);
    end

    // Final pulse with bank_final_ready low, then a long result stall and abort in DONE.
    step(1, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 1, 11, 0, 0, 0, 0);
    idle();
    step(0, 0, 0, 0, 1, 0, 0, 0);
    step(0, 0, 1, 12, 0, 0, 0, 0);
    idle();
    step(0, 0, 0, 0, 1, 0, 'hBEEF, 0);
    exp_done = pack(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, NRnd'(2),
                    FW'(12), FW'(Q - 11), FW'('hBEEF));
    idle();
    #1;
    check("done_latency", pack_dut(), exp_done);
    for (int k = 0; k < 5; k++) begin
      idle();
      #1;
      check($sformatf("done_hold%0d", k), pack_dut(), exp_done);
    end
    step(0, 1, 0, 0, 0, 0, 0, 1);
    idle();
    #1;
    check("done_abort", 64'({bus.result_valid, bus.busy, bus.start_ready}), 64'(3'b001));

    // Tau stall, then asynchronous reset in FIRE, then restart after reset.
    step(1, 0, 0, 0, 0, 0, 0, 0);
    for (int k = 0; k < 10; k++) begin
      idle();
      #1;
      check($sformatf("tau_stall%0d", k),
            64'({bus.tau_ready, bus.bank_en, bus.busy, bus.round}), 64'({3'b101, NRnd'(0)}));
    end
    step(0, 0, 1, 20, 0, 0, 0, 0);
    idle();
    #1;
    check("fire_pre_rst", 64'({bus.bank_en, bus.bank_restart, bus.bank_tau, bus.bank_m_tau_p1}),
          64'({2'b11, FW'(20), FW'(Q - 19)}));
    #1;
    rst = 1'b1;
    #1;
    check("async_rst", pack_dut(), reset_pack);
    @(negedge clk);
    rst = 1'b0;
    step(1, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 1, 1, 0, 0, 0, 0);
    idle();
    #1;
    check("restart_after_rst", 64'({bus.bank_en, bus.bank_restart, bus.bank_m_tau_p1}),
          64'({2'b11, FW'(Q)}));

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
